// File: rtl/cbi980_pkg.sv
// cbi980 audio core shared definitions.
// Word width, slot layout and PHY sequencing states.
package cbi980_pkg;

  localparam int AUD_W     = 24;
  localparam int SLOT_BITS = 32;
  localparam int MSB_BIT   = 1;
  localparam int LSB_BIT   = 24;

  typedef enum logic [1:0] {
    RST  = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } phy_st_e;

  // slot bits that carry audio data
  function automatic logic data_slot(
    input logic [4:0] b
  );
    return (b >= 5'(MSB_BIT)) &&
           (b <= 5'(LSB_BIT));
  endfunction

endpackage

// File: rtl/cbi980_i2s_clkgen.sv
// cbi980 I2S clock generator: divider, rate latch,
// MCLK/SCLK/LRCLK and SCLK edge events with frame bit counter.
module cbi980_i2s_clkgen #(
  parameter int DIV_W = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       latch,
  input  logic       run,
  input  logic [2:0] mclk_rate,
  input  logic [2:0] sclk_rate,
  output logic       fall_ev,
  output logic       rise_ev,
  output logic [5:0] bitcnt,
  output logic       codec_mclk,
  output logic       codec_sclk,
  output logic       codec_lrclk
);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] mask;
  logic [DIV_W-1:0] low;
  logic [2:0]       mr;
  logic [2:0]       sr;
  logic [3:0]       k;
  logic [4:0]       k1;

  assign k    = {1'b0, mr} + {1'b0, sr};
  assign k1   = {1'b0, k} + 5'd1;
  assign mask = ~({DIV_W{1'b1}} << k1);
  assign low  = div & mask;

  // div[k] is about to drop / about to rise
  assign fall_ev = (low == mask);
  assign rise_ev = (low == (mask >> 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div         <= '0;
      mr          <= '0;
      sr          <= '0;
      bitcnt      <= '0;
      codec_mclk  <= 1'b0;
      codec_sclk  <= 1'b0;
      codec_lrclk <= 1'b0;
    end else begin
      div <= div + 1'b1;
      if (latch) begin
        mr <= mclk_rate;
        sr <= sclk_rate;
      end
      if (!run)
        bitcnt <= '0;
      else if (fall_ev)
        bitcnt <= bitcnt + 6'd1;
      codec_mclk  <= div[mr];
      codec_sclk  <= div[k] & run;
      codec_lrclk <= bitcnt[5];
    end
  end

endmodule

// File: rtl/cbi980_i2s_phy.sv
// cbi980 codec-side I2S PHY: codec power-up sequence,
// 24-bit TX serializer and RX deserializer with per-channel pulses.
module cbi980_i2s_phy
  import cbi980_pkg::*;
#(
  parameter int RST_CYCLES  = 1024,
  parameter int INIT_CYCLES = 4096,
  parameter int DIV_W       = 16
) (
  input  logic             clk,
  input  logic             rstn,
  output logic             init_done,
  input  logic [2:0]       mclk_rate,
  input  logic [2:0]       sclk_rate,
  output logic             codec_rstn,
  output logic             codec_mclk,
  output logic             codec_lrclk,
  output logic             codec_sclk,
  output logic             codec_sdin,
  input  logic             codec_sdout,
  output logic [1:0]       aud_dout_vld,
  output logic [AUD_W-1:0] aud_dout,
  output logic [1:0]       aud_din_ack,
  input  logic [AUD_W-1:0] aud_din0,
  input  logic [AUD_W-1:0] aud_din1
);

  localparam int CNT_MAX =
    (RST_CYCLES > INIT_CYCLES) ? RST_CYCLES : INIT_CYCLES;
  localparam int CNT_W = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

  phy_st_e          st;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic             latch;
  logic             fall_ev;
  logic             rise_ev;
  logic [5:0]       bitcnt;
  logic [5:0]       nxt_bit;
  logic             go;
  logic [AUD_W-1:0] tx_sh;
  logic [AUD_W-1:0] rx_sh;
  logic             rx_last;
  logic             rx_ch;
  logic             wait_done;

  assign run       = (st == RUN);
  assign latch     = (st == RST);
  assign wait_done = (st == WAIT) && (cnt == INIT_LAST);

  cbi980_i2s_clkgen #(
    .DIV_W(DIV_W)
  ) u_clkgen (
    .clk        (clk),
    .rstn       (rstn),
    .latch      (latch),
    .run        (run),
    .mclk_rate  (mclk_rate),
    .sclk_rate  (sclk_rate),
    .fall_ev    (fall_ev),
    .rise_ev    (rise_ev),
    .bitcnt     (bitcnt),
    .codec_mclk (codec_mclk),
    .codec_sclk (codec_sclk),
    .codec_lrclk(codec_lrclk)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st         <= RST;
      cnt        <= '0;
      codec_rstn <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      unique case (st)
        RST: begin
          if (cnt == RST_LAST) begin
            st         <= WAIT;
            cnt        <= '0;
            codec_rstn <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (cnt != INIT_LAST) begin
            cnt <= cnt + 1'b1;
          end else if (fall_ev) begin
            st        <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN:     st <= RUN;
        default: st <= RST;
      endcase
    end
  end

  // RUN entry counts as the fall_ev into slot bit 0 of ch0
  assign go      = fall_ev & (run | wait_done);
  assign nxt_bit = run ? (bitcnt + 6'd1) : 6'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_sh       <= '0;
      codec_sdin  <= 1'b0;
      aud_din_ack <= '0;
    end else begin
      aud_din_ack <= '0;
      if (go) begin
        if (nxt_bit[4:0] == 5'd0) begin
          tx_sh       <= nxt_bit[5] ? aud_din1 : aud_din0;
          aud_din_ack <= nxt_bit[5] ? 2'b10 : 2'b01;
          codec_sdin  <= 1'b0;
        end else if (data_slot(nxt_bit[4:0])) begin
          codec_sdin <= tx_sh[AUD_W-1];
          tx_sh      <= tx_sh << 1;
        end else begin
          codec_sdin <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_sh        <= '0;
      rx_last      <= 1'b0;
      rx_ch        <= 1'b0;
      aud_dout     <= '0;
      aud_dout_vld <= '0;
    end else begin
      rx_last      <= 1'b0;
      aud_dout_vld <= '0;
      if (run && rise_ev && data_slot(bitcnt[4:0])) begin
        rx_sh   <= {rx_sh[AUD_W-2:0], codec_sdout};
        rx_last <= (bitcnt[4:0] == 5'(LSB_BIT));
        rx_ch   <= bitcnt[5];
      end
      if (rx_last) begin
        aud_dout     <= rx_sh;
        aud_dout_vld <= rx_ch ? 2'b10 : 2'b01;
      end
    end
  end

endmodule
